sgpr_retire_arbiter: RTL and testbench
======================================

Name: sgpr_retire_arbiter

Overview:
- Upstream feeder of the issue-stage SGPR comparator. Collects SGPR write-retire events from SALU, VALU (VCC/SGPR-destination compares) and LSU (scalar loads).
- Buffers each source in a small FIFO and round-robin arbitrates among them.
- Presents one registered retired operand per cycle: wavefront id, base address and word mask. The comparator and scoreboard consume it to clear pending-operand bits.

Parameters:
- SGPR_ADDR_W, 9, SGPR address width; equals the global SGPR_ADDR_LENGTH.
- WFID_W, 6, wavefront id width.
- FIFO_DEPTH, 4, entries per source FIFO; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- salu_retire_valid  input  1  SALU retire event this cycle.
- salu_retire_wfid  input  WFID_W  SALU event wavefront.
- salu_retire_addr  input  SGPR_ADDR_W  SALU destination base SGPR.
- salu_retire_mask  input  4  SALU word mask.
- valu_retire_valid / valu_retire_wfid / valu_retire_addr / valu_retire_mask  input  1/WFID_W/SGPR_ADDR_W/4  same fields, VALU source.
- lsu_retire_valid / lsu_retire_wfid / lsu_retire_addr / lsu_retire_mask  input  1/WFID_W/SGPR_ADDR_W/4  same fields, LSU source.
- retired_ready  input  1  consumer accepts the current output.
- retired_valid  output  1  output slot holds an event.
- retired_wfid  output  WFID_W  event wavefront.
- retired_operand_addr  output  SGPR_ADDR_W  event base address.
- retired_operand_mask  output  4  event word mask.
- salu_fifo_full / valu_fifo_full / lsu_fifo_full  output  1 each  per-source FIFO full.
- overflow_err  output  1  sticky: an event was dropped because its FIFO was full.
- mask_err  output  1  sticky: an event carried an illegal mask.

Behaviour:
- Reset (async, rst=1):
  - FIFOs are emptied.
  - retired_valid=0; retired_wfid, retired_operand_addr and retired_operand_mask are 0.
  - All *_fifo_full=0.
  - overflow_err=0 and mask_err=0.
  - Round-robin pointer set to SALU.
  - Reset asserted mid-operation discards all buffered and output events.
- Legal masks are 4'b0001, 4'b0011 and 4'b1111.
  - For the SALU and VALU sources, 4'b1111 is also illegal.
  - An event with an illegal mask is not pushed and sets mask_err.
- Address alignment is not checked.
- Push rule:
  - A legal event is pushed at the clock edge if its FIFO count < FIFO_DEPTH. The count is the registered value.
  - If the FIFO is full, the event is dropped and overflow_err is set. This applies even if the same FIFO pops in that cycle.
- *_fifo_full is high exactly when the registered count == FIFO_DEPTH.
- Output slot is a single register; slot_free = !retired_valid | retired_ready.
  - Load: when slot_free and at least one FIFO is non-empty, the round-robin winner's head entry is popped and loaded into the output register.
  - Empty: when slot_free and all FIFOs are empty, retired_valid goes to 0. The data fields hold their last values.
  - Hold: when retired_valid=1 and retired_ready=0, all outputs hold and nothing pops.
- Round-robin:
  - Search order starts at the pointer and proceeds SALU→VALU→LSU→SALU.
  - After a grant, the pointer moves to the source after the winner.
  - With no grant, the pointer is unchanged.
- Latency:
  - An event sampled at edge E becomes visible on the outputs after edge E+1 at the earliest, i.e. minimum 1 cycle of buffering. There is no bypass path.
- Simultaneous push and pop on the same FIFO: the count is unchanged; pointers wrap modulo FIFO_DEPTH.
- All three sources may push in the same cycle. Only one event leaves per cycle.
- Per-source order is preserved. There is no ordering guarantee across sources.

Decomposition:
- Shared package (issue definitions):
  - mask constants MASK_1W=4'b0001, MASK_2W=4'b0011, MASK_4W=4'b1111;
  - source encodings SRC_SALU=0, SRC_VALU=1, SRC_LSU=2;
  - retire-entry field widths.
- Sub-module sgpr_retire_fifo:
  - parameterised width and depth; async reset;
  - ports push, pop, din, dout, empty, full;
  - instantiated three times.
- Arbiter and output register live in the top module.

Test Plan:
- Reset then idle: retired_valid=0 and all flags 0. Assert rst mid-stream with 3 entries buffered → all outputs return to 0 immediately and no stale event appears after release.
- Single SALU event wfid=5, addr=9'h010, mask=0011, retired_ready=1 → one cycle later retired_valid=1 with wfid=5, addr=0x010, mask=0011, for exactly one cycle.
- SALU, VALU and LSU push in the same cycle (addr 0x20, 0x40, 0x60), ready=1 → outputs in order 0x20, 0x40, 0x60 on consecutive cycles. A following simultaneous triple starts from SALU again.
- retired_ready=0, 5 LSU events addr 0x00..0x04 with FIFO_DEPTH=4:
  - lsu_fifo_full=1; the 5th event is dropped; overflow_err=1.
  - After ready=1, the outputs show the one held event, then the remaining buffered events in push order.
- SALU event with mask=1111 → not emitted and mask_err=1. LSU event with mask=1111, addr=0x08 → emitted unchanged.
- Ready toggles 1,0,0,1 with a continuous VALU stream → the output is held stable while ready=0, with no loss and no duplication.

Source files
------------

// File: rtl/sgpr_retire_arbiter_pkg.sv
// rtl/sgpr_retire_arbiter_pkg.sv - shared definitions for the SGPR retire arbiter
package sgpr_retire_arbiter_pkg;

    // Retire-entry field widths
    localparam int SGPR_ADDR_LENGTH = 9;
    localparam int WFID_LENGTH      = 6;
    localparam int MASK_W           = 4;

    // Word masks a retire event may carry
    localparam logic [MASK_W-1:0] MASK_1W = 4'b0001;
    localparam logic [MASK_W-1:0] MASK_2W = 4'b0011;
    localparam logic [MASK_W-1:0] MASK_4W = 4'b1111;

    // Source encodings, also the round-robin search order
    localparam logic [1:0] SRC_SALU = 2'd0;
    localparam logic [1:0] SRC_VALU = 2'd1;
    localparam logic [1:0] SRC_LSU  = 2'd2;
    localparam int         NUM_SRC  = 3;

    // Four-word writes only come from scalar loads, so only LSU may use MASK_4W
    function automatic logic mask_legal(input logic [MASK_W-1:0] m, input logic allow_4w);
        return (m == MASK_1W) || (m == MASK_2W) || (allow_4w && (m == MASK_4W));
    endfunction

    // Next source in the SALU -> VALU -> LSU -> SALU ring
    function automatic logic [1:0] src_next(input logic [1:0] s);
        return (s == SRC_LSU) ? SRC_SALU : s + 2'd1;
    endfunction

endpackage

// File: rtl/sgpr_retire_arbiter_if.sv
// rtl/sgpr_retire_arbiter_if.sv - retire event inputs, retired operand output and status flags
interface sgpr_retire_arbiter_if
    import sgpr_retire_arbiter_pkg::*;
#(
    parameter int SGPR_ADDR_W = SGPR_ADDR_LENGTH,
    parameter int WFID_W      = WFID_LENGTH
);
    logic                   salu_retire_valid;
    logic [WFID_W-1:0]      salu_retire_wfid;
    logic [SGPR_ADDR_W-1:0] salu_retire_addr;
    logic [MASK_W-1:0]      salu_retire_mask;
    logic                   valu_retire_valid;
    logic [WFID_W-1:0]      valu_retire_wfid;
    logic [SGPR_ADDR_W-1:0] valu_retire_addr;
    logic [MASK_W-1:0]      valu_retire_mask;
    logic                   lsu_retire_valid;
    logic [WFID_W-1:0]      lsu_retire_wfid;
    logic [SGPR_ADDR_W-1:0] lsu_retire_addr;
    logic [MASK_W-1:0]      lsu_retire_mask;
    logic                   retired_ready;
    logic                   retired_valid;
    logic [WFID_W-1:0]      retired_wfid;
    logic [SGPR_ADDR_W-1:0] retired_operand_addr;
    logic [MASK_W-1:0]      retired_operand_mask;
    logic                   salu_fifo_full;
    logic                   valu_fifo_full;
    logic                   lsu_fifo_full;
    logic                   overflow_err;
    logic                   mask_err;

    // Producers and the consumer drive the event inputs and ready
    modport master (
        output salu_retire_valid, salu_retire_wfid, salu_retire_addr, salu_retire_mask,
        output valu_retire_valid, valu_retire_wfid, valu_retire_addr, valu_retire_mask,
        output lsu_retire_valid, lsu_retire_wfid, lsu_retire_addr, lsu_retire_mask,
        output retired_ready,
        input  retired_valid, retired_wfid, retired_operand_addr, retired_operand_mask,
        input  salu_fifo_full, valu_fifo_full, lsu_fifo_full, overflow_err, mask_err
    );

    // The arbiter consumes events and presents the retired operand
    modport slave (
        input  salu_retire_valid, salu_retire_wfid, salu_retire_addr, salu_retire_mask,
        input  valu_retire_valid, valu_retire_wfid, valu_retire_addr, valu_retire_mask,
        input  lsu_retire_valid, lsu_retire_wfid, lsu_retire_addr, lsu_retire_mask,
        input  retired_ready,
        output retired_valid, retired_wfid, retired_operand_addr, retired_operand_mask,
        output salu_fifo_full, valu_fifo_full, lsu_fifo_full, overflow_err, mask_err
    );
endinterface

// File: rtl/sgpr_retire_arbiter_fifo.sv
// rtl/sgpr_retire_arbiter_fifo.sv - per-source retire event FIFO
module sgpr_retire_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sgpr_retire_arbiter.sv
// rtl/sgpr_retire_arbiter.sv - buffers SALU/VALU/LSU SGPR retire events and emits one per cycle
module sgpr_retire_arbiter
    import sgpr_retire_arbiter_pkg::*;
#(
    parameter int SGPR_ADDR_W = SGPR_ADDR_LENGTH,
    parameter int WFID_W      = WFID_LENGTH,
    parameter int FIFO_DEPTH  = 4
) (
    input logic                   clk,
    input logic                   rst,
    sgpr_retire_arbiter_if.slave  bus
);
    localparam int ENTRY_W = WFID_W + SGPR_ADDR_W + MASK_W;

    logic [NUM_SRC-1:0] src_valid, src_legal, push_vec, pop_vec, full_vec, empty_vec;
    logic [ENTRY_W-1:0] src_entry [NUM_SRC];
    logic [ENTRY_W-1:0] fifo_dout [NUM_SRC];
    logic [1:0]         cand [NUM_SRC];
    logic [1:0]         grant_src;
    logic               grant_any, slot_free, load;

    logic [1:0]             rr_q, rr_d;
    logic                   valid_q, valid_d;
    logic [WFID_W-1:0]      wfid_q, wfid_d;
    logic [SGPR_ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0]      mask_q, mask_d;
    logic                   overflow_err_q, overflow_err_d, mask_err_q, mask_err_d;

    // Gather the three sources into indexable vectors and qualify their masks
    always_comb begin
        src_valid = {bus.lsu_retire_valid, bus.valu_retire_valid, bus.salu_retire_valid};
        src_entry[SRC_SALU] = {bus.salu_retire_wfid, bus.salu_retire_addr, bus.salu_retire_mask};
        src_entry[SRC_VALU] = {bus.valu_retire_wfid, bus.valu_retire_addr, bus.valu_retire_mask};
        src_entry[SRC_LSU]  = {bus.lsu_retire_wfid,  bus.lsu_retire_addr,  bus.lsu_retire_mask};
        src_legal[SRC_SALU] = src_valid[SRC_SALU] && mask_legal(bus.salu_retire_mask, 1'b0);
        src_legal[SRC_VALU] = src_valid[SRC_VALU] && mask_legal(bus.valu_retire_mask, 1'b0);
        src_legal[SRC_LSU]  = src_valid[SRC_LSU]  && mask_legal(bus.lsu_retire_mask, 1'b1);
        push_vec = src_legal & ~full_vec;
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
        sgpr_retire_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_vec[s]),
            .pop   (pop_vec[s]),
            .din   (src_entry[s]),
            .dout  (fifo_dout[s]),
            .empty (empty_vec[s]),
            .full  (full_vec[s])
        );
    end

    // Round-robin search from the pointer; descending loop leaves the first hit as winner
    always_comb begin
        cand[0]   = rr_q;
        cand[1]   = src_next(rr_q);
        cand[2]   = src_next(cand[1]);
        grant_any = 1'b0;
        grant_src = rr_q;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!empty_vec[cand[i]]) begin
                grant_any = 1'b1;
                grant_src = cand[i];
            end
        end
        slot_free = !valid_q || bus.retired_ready;
        load      = slot_free && grant_any;
        for (int i = 0; i < NUM_SRC; i++) pop_vec[i] = load && (grant_src == 2'(i));
    end

    // Output slot, round-robin pointer and sticky error flags
    always_comb begin
        rr_d           = rr_q;
        valid_d        = valid_q;
        wfid_d         = wfid_q;
        addr_d         = addr_q;
        mask_d         = mask_q;
        overflow_err_d = overflow_err_q || (|(src_legal & full_vec));
        mask_err_d     = mask_err_q || (|(src_valid & ~src_legal));
        if (load) begin
            valid_d                  = 1'b1;
            {wfid_d, addr_d, mask_d} = fifo_dout[grant_src];
            rr_d                     = src_next(grant_src);
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    // Registered state with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q           <= SRC_SALU;
            valid_q        <= 1'b0;
            wfid_q         <= '0;
            addr_q         <= '0;
            mask_q         <= '0;
            overflow_err_q <= 1'b0;
            mask_err_q     <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            valid_q        <= valid_d;
            wfid_q         <= wfid_d;
            addr_q         <= addr_d;
            mask_q         <= mask_d;
            overflow_err_q <= overflow_err_d;
            mask_err_q     <= mask_err_d;
        end
    end

    assign bus.retired_valid        = valid_q;
    assign bus.retired_wfid         = wfid_q;
    assign bus.retired_operand_addr = addr_q;
    assign bus.retired_operand_mask = mask_q;
    assign bus.salu_fifo_full       = full_vec[SRC_SALU];
    assign bus.valu_fifo_full       = full_vec[SRC_VALU];
    assign bus.lsu_fifo_full        = full_vec[SRC_LSU];
    assign bus.overflow_err         = overflow_err_q;
    assign bus.mask_err             = mask_err_q;
endmodule

// File: tb/tb_sgpr_retire_arbiter.sv
// tb/tb_sgpr_retire_arbiter.sv - directed self-checking bench for sgpr_retire_arbiter
module tb_sgpr_retire_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sgpr_retire_arbiter_if #(.SGPR_ADDR_W(9), .WFID_W(6)) bus ();

    sgpr_retire_arbiter #(.SGPR_ADDR_W(9), .WFID_W(6), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.salu_retire_valid = 1'b0; bus.salu_retire_wfid = '0; bus.salu_retire_addr = '0; bus.salu_retire_mask = '0;
        bus.valu_retire_valid = 1'b0; bus.valu_retire_wfid = '0; bus.valu_retire_addr = '0; bus.valu_retire_mask = '0;
        bus.lsu_retire_valid  = 1'b0; bus.lsu_retire_wfid  = '0; bus.lsu_retire_addr  = '0; bus.lsu_retire_mask  = '0;
    endtask

    task automatic drive(input int src, input logic [5:0] w, input logic [8:0] a, input logic [3:0] m);
        case (src)
            0: begin bus.salu_retire_valid = 1'b1; bus.salu_retire_wfid = w; bus.salu_retire_addr = a; bus.salu_retire_mask = m; end
            1: begin bus.valu_retire_valid = 1'b1; bus.valu_retire_wfid = w; bus.valu_retire_addr = a; bus.valu_retire_mask = m; end
            default: begin bus.lsu_retire_valid = 1'b1; bus.lsu_retire_wfid = w; bus.lsu_retire_addr = a; bus.lsu_retire_mask = m; end
        endcase
    endtask

    task automatic do_reset;
        clear_inputs();
        bus.retired_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.retired_valid); end
        checks++; if ({bus.retired_wfid, bus.retired_operand_addr, bus.retired_operand_mask} !== 19'h0) begin
            errors++; $display("FAIL reset_fields: got %h want 0", {bus.retired_wfid, bus.retired_operand_addr, bus.retired_operand_mask}); end
        checks++; if ({bus.salu_fifo_full, bus.valu_fifo_full, bus.lsu_fifo_full} !== 3'b000) begin
            errors++; $display("FAIL reset_full: got %b want 000", {bus.salu_fifo_full, bus.valu_fifo_full, bus.lsu_fifo_full}); end
        checks++; if ({bus.overflow_err, bus.mask_err} !== 2'b00) begin
            errors++; $display("FAIL reset_err: got %b want 00", {bus.overflow_err, bus.mask_err}); end
        rst = 1'b0;
        bus.retired_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", bus.retired_valid); end
    endtask

    task automatic test_single;
        drive(0, 6'd5, 9'h010, 4'b0011);
        tick();
        clear_inputs();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", bus.retired_valid); end
        tick();
        checks++; if (bus.retired_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.retired_valid); end
        checks++; if (bus.retired_wfid !== 6'd5) begin errors++; $display("FAIL single_wfid: got %0d want 5", bus.retired_wfid); end
        checks++; if (bus.retired_operand_addr !== 9'h010) begin errors++; $display("FAIL single_addr: got %h want 010", bus.retired_operand_addr); end
        checks++; if (bus.retired_operand_mask !== 4'b0011) begin errors++; $display("FAIL single_mask: got %b want 0011", bus.retired_operand_mask); end
        tick();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", bus.retired_valid); end
    endtask

    task automatic test_triple;
        logic [8:0] exp_addr [3];
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_addr[0] = 9'h020 + 9'(r);
            exp_addr[1] = 9'h040 + 9'(r);
            exp_addr[2] = 9'h060 + 9'(r);
            drive(0, 6'd1, exp_addr[0], 4'b0001);
            drive(1, 6'd2, exp_addr[1], 4'b0001);
            drive(2, 6'd3, exp_addr[2], 4'b0011);
            tick();
            clear_inputs();
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== exp_addr[k]) begin
                    errors++; $display("FAIL triple_order round %0d slot %0d: got valid %b addr %h want 1 %h", r, k, bus.retired_valid, bus.retired_operand_addr, exp_addr[k]); end
            end
            tick();
            checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL triple_drain round %0d: got %b want 0", r, bus.retired_valid); end
        end
    endtask

    task automatic test_overflow;
        do_reset();
        bus.retired_ready = 1'b0;
        drive(0, 6'd9, 9'h1FF, 4'b0001);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== 9'h1FF) begin
            errors++; $display("FAIL ovf_slot_load: got valid %b addr %h want 1 1ff", bus.retired_valid, bus.retired_operand_addr); end
        for (int k = 0; k < 5; k++) begin
            drive(2, 6'd1, 9'(k), 4'b0001);
            if (k == 4) begin
                checks++; if (bus.lsu_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.lsu_fifo_full); end
                checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", bus.overflow_err); end
            end
            tick();
        end
        clear_inputs();
        checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus.overflow_err); end
        tick();
        tick();
        checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== 9'h1FF || bus.retired_wfid !== 6'd9) begin
            errors++; $display("FAIL ovf_hold: got valid %b addr %h wfid %0d want 1 1ff 9", bus.retired_valid, bus.retired_operand_addr, bus.retired_wfid); end
        bus.retired_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== 9'(k)) begin
                errors++; $display("FAIL ovf_drain %0d: got valid %b addr %h want 1 %h", k, bus.retired_valid, bus.retired_operand_addr, 9'(k)); end
            if (k == 0) begin
                checks++; if (bus.lsu_fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full_clear: got %b want 0", bus.lsu_fifo_full); end
            end
        end
        tick();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got valid %b addr %h want 0", bus.retired_valid, bus.retired_operand_addr); end
    endtask

    task automatic test_mask;
        do_reset();
        drive(2, 6'd7, 9'h008, 4'b1111);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== 9'h008 || bus.retired_operand_mask !== 4'b1111 || bus.retired_wfid !== 6'd7) begin
            errors++; $display("FAIL mask_lsu_4w: got valid %b addr %h mask %b wfid %0d want 1 008 1111 7",
                               bus.retired_valid, bus.retired_operand_addr, bus.retired_operand_mask, bus.retired_wfid); end
        checks++; if (bus.mask_err !== 1'b0) begin errors++; $display("FAIL mask_lsu_err: got %b want 0", bus.mask_err); end
        drive(0, 6'd2, 9'h030, 4'b1111);
        tick();
        clear_inputs();
        checks++; if (bus.mask_err !== 1'b1) begin errors++; $display("FAIL mask_salu_err: got %b want 1", bus.mask_err); end
        tick();
        checks++; if (bus.retired_valid !== 1'b0) begin errors++; $display("FAIL mask_salu_drop: got valid %b addr %h want 0", bus.retired_valid, bus.retired_operand_addr); end
        tick();
        checks++; if (bus.retired_valid !== 1'b0 || bus.mask_err !== 1'b1) begin
            errors++; $display("FAIL mask_sticky: got valid %b err %b want 0 1", bus.retired_valid, bus.mask_err); end
    endtask

    task automatic test_ready_toggle;
        int         exp_n;
        logic       pv, pr;
        logic [8:0] pa;
        exp_n = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            clear_inputs();
            if (c < 6) drive(1, 6'd4, 9'h050 + 9'(c), 4'b0011);
            bus.retired_ready = ((c % 4) == 0) || ((c % 4) == 3);
            pv = bus.retired_valid;
            pr = bus.retired_ready;
            pa = bus.retired_operand_addr;
            tick();
            if (pv && pr) begin
                checks++; if (pa !== 9'h050 + 9'(exp_n)) begin
                    errors++; $display("FAIL toggle_order cycle %0d: got %h want %h", c, pa, 9'h050 + 9'(exp_n)); end
                exp_n++;
            end else if (pv && !pr) begin
                checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== pa) begin
                    errors++; $display("FAIL toggle_hold cycle %0d: got valid %b addr %h want 1 %h", c, bus.retired_valid, bus.retired_operand_addr, pa); end
            end
        end
        clear_inputs();
        checks++; if (exp_n !== 6) begin errors++; $display("FAIL toggle_count: got %0d want 6", exp_n); end
        checks++; if (bus.retired_valid !== 1'b0 || bus.overflow_err !== 1'b0) begin
            errors++; $display("FAIL toggle_end: got valid %b ovf %b want 0 0", bus.retired_valid, bus.overflow_err); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.retired_ready = 1'b0;
        drive(0, 6'd1, 9'h070, 4'b0001);
        drive(1, 6'd2, 9'h071, 4'b0001);
        drive(2, 6'd3, 9'h072, 4'b0001);
        tick();
        clear_inputs();
        drive(0, 6'd1, 9'h073, 4'b1111);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.retired_valid !== 1'b1 || bus.retired_operand_addr !== 9'h070 || bus.mask_err !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got valid %b addr %h merr %b want 1 070 1", bus.retired_valid, bus.retired_operand_addr, bus.mask_err); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.retired_valid !== 1'b0 || {bus.retired_wfid, bus.retired_operand_addr, bus.retired_operand_mask} !== 19'h0) begin
            errors++; $display("FAIL mid_async_clear: got valid %b fields %h want 0 0", bus.retired_valid,
                               {bus.retired_wfid, bus.retired_operand_addr, bus.retired_operand_mask}); end
        checks++; if (bus.mask_err !== 1'b0) begin errors++; $display("FAIL mid_err_clear: got %b want 0", bus.mask_err); end
        tick();
        rst = 1'b0;
        bus.retired_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.retired_valid !== 1'b0) begin
                errors++; $display("FAIL mid_stale %0d: got valid %b addr %h want 0", k, bus.retired_valid, bus.retired_operand_addr); end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        bus.retired_ready = 1'b0;
        test_reset();
        test_single();
        test_triple();
        test_overflow();
        test_mask();
        test_ready_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
